// File: rtl/pam_mult_pkg.sv
// Shared constants, the round-robin pick result type and the round-robin
// search used by the multiplier scheduler.
package pam_mult_pkg;

    localparam int unsigned OP_W     = 8;
    localparam int unsigned PROD_W   = 16;
    localparam int unsigned MAX_REQ  = 8;
    localparam int unsigned RR_IDX_W = 3;
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    typedef struct packed {
        logic                hit;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid[0..n-1], searching from ptr+1 and wrapping at n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input int unsigned        ptr,
                                         input int unsigned        n);
        rr_pick_t    r;
        int unsigned idx;
        r = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (!r.hit && valid[idx[RR_IDX_W-1:0]]) begin
                    r.hit = 1'b1;
                    r.idx = idx[RR_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pam_mult_sched_arb.sv
// Round-robin arbiter: one-hot grant gated by en; the pointer moves to the
// granted requester so it becomes lowest priority on the next search.
module pam_rr_arb
    import pam_mult_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    logic [ID_W-1:0] ptr;
    rr_pick_t        pick;

    // Search from ptr+1; grant only while the pipeline can advance.
    always_comb begin
        pick   = rr_pick(MAX_REQ'(req), 32'(ptr), NUM_REQ);
        gnt_id = ID_W'(pick.idx);
        gnt    = '0;
        if (en && pick.hit) gnt[gnt_id] = 1'b1;
    end

    // Pointer starts at the last requester so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= ID_W'(NUM_REQ - 1);
        end else if (en && pick.hit) begin
            ptr <= gnt_id;
        end
    end

endmodule

// File: rtl/pam_mult_sched.sv
// Shares one external combinational 8x8 multiplier core among NUM_REQ
// requesters: round-robin accept, operand register feeding mul_x/mul_y,
// product captured into a stallable result pipeline carrying id and tag.
// Optional grant statistics are built when PAM_MULT_STATS_EN is defined.
module pam_mult_sched
    import pam_mult_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned PIPE    = 2,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*8-1:0]     req_x,
    input  logic [NUM_REQ*8-1:0]     req_y,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [7:0]               mul_x,
    output logic [7:0]               mul_y,
    input  logic [15:0]              mul_z,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [15:0]              res_z,
    output logic [ID_W-1:0]          res_id,
    output logic [TAG_W-1:0]         res_tag,
    output logic                     busy,
    input  logic [ID_W-1:0]          stat_sel,
    output logic [15:0]              stat_cnt
);

    typedef struct packed {
        logic              valid;
        logic [PROD_W-1:0] z;
        logic [ID_W-1:0]   id;
        logic [TAG_W-1:0]  tag;
    } stage_t;

    logic               adv;
    logic               xfer;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;

    logic               s0_valid;
    logic [ID_W-1:0]    s0_id;
    logic [TAG_W-1:0]   s0_tag;
    logic [OP_W-1:0]    s0_x;
    logic [OP_W-1:0]    s0_y;
    logic [OP_W-1:0]    sel_x;
    logic [OP_W-1:0]    sel_y;
    logic [TAG_W-1:0]   sel_tag;

    stage_t             pipe [1:PIPE-1];
    stage_t             res_st;

    assign adv       = !res_valid || res_ready;
    assign xfer      = |gnt;
    assign req_ready = gnt;

    pam_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .en     (adv),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Route the granted requester's operands and tag toward stage 0.
    always_comb begin
        sel_x   = req_x[32'(gnt_id)*OP_W +: OP_W];
        sel_y   = req_y[32'(gnt_id)*OP_W +: OP_W];
        sel_tag = req_tag[32'(gnt_id)*TAG_W +: TAG_W];
    end

    // Stage 0: operand register driving the core; holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_x     <= '0;
            s0_y     <= '0;
            s0_id    <= '0;
            s0_tag   <= '0;
        end else if (adv) begin
            s0_valid <= xfer;
            if (xfer) begin
                s0_x   <= sel_x;
                s0_y   <= sel_y;
                s0_id  <= gnt_id;
                s0_tag <= sel_tag;
            end
        end
    end

    assign mul_x = s0_x;
    assign mul_y = s0_y;

    // Stages 1..PIPE-1: capture the core product, then shift on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < PIPE; i++) pipe[i] <= '0;
        end else if (adv) begin
            pipe[1] <= '{valid: s0_valid, z: mul_z, id: s0_id, tag: s0_tag};
            for (int unsigned i = 2; i < PIPE; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign res_st    = pipe[PIPE-1];
    assign res_valid = res_st.valid;
    assign res_z     = res_st.z;
    assign res_id    = res_st.id;
    assign res_tag   = res_st.tag;

    // Busy while any stage holds a live request.
    always_comb begin
        busy = s0_valid;
        for (int unsigned i = 1; i < PIPE; i++) busy = busy | pipe[i].valid;
    end

`ifdef PAM_MULT_STATS_EN
    logic [15:0] cnt [NUM_REQ];

    // Per-requester saturating grant counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && cnt[i] != STAT_MAX) cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    // Counter readback; out-of-range selects read as zero.
    always_comb begin
        stat_cnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(stat_sel) == i) stat_cnt = cnt[i];
        end
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_cnt        = '0;
`endif

endmodule
